fpm_stream_feeder: RTL and testbench

//  Upstream feeder for the registered FP32 multiplier (sync_fpm).
//  - Accepts operand pairs on a valid/ready stream and derives the isZeroA/isZeroB flags.
//  - Drives the multiplier and tracks its fixed pipeline latency.
//  - Catches each product with its isZeroOut flag in a small FIFO, so the consumer can stall without losing results.

---
 rtl/fpm_pkg.sv | 17 +
 rtl/fpm_result_fifo.sv | 64 ++++++
 rtl/fpm_stream_feeder.sv | 101 ++++++++++
 tb/tb_fpm_stream_feeder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared FP32 definitions for the multiplier feeder slice.
// Provides IEEE-754 single-precision field positions and the flush-to-zero
// detector used to build the isZeroA/isZeroB flags.
package fpm_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MANT_MSB = 22;

    // A zero exponent field covers +0, -0 and every denormal, so denormals
    // are flushed to zero by the multiplier.
    function automatic logic is_fp_zero(input logic [31:0] x);
        return x[EXP_MSB:EXP_LSB] == '0;
    endfunction

endpackage

// File: rtl/fpm_result_fifo.sv
// Result FIFO that catches multiplier products with their zero flag.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   push       - write push_data into the tail
//   push_data  - WIDTH-bit entry
//   pop        - discard the head entry
//   pop_data   - registered head entry
//   count      - number of stored entries (0..DEPTH)
// A push and pop in the same cycle is accepted at any occupancy, full included.
module fpm_result_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        full     = count_q == (PW+1)'(DEPTH);
        empty    = count_q == '0;
        do_pop   = pop && !empty;
        // When full, the slot being written is the one being popped this cycle.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + (do_push ? PW'(1) : '0);
        rd_ptr_d = rd_ptr_q + (do_pop ? PW'(1) : '0);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            assert (!(push && full && !pop));
        end
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fpm_stream_feeder.sv
// Upstream feeder for the registered FP32 multiplier.
// Ports:
//   clk, rst                  - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_a/b  - operand pair stream
//   mul_a/mul_b/mul_zero_a/b  - operands and zero flags to the multiplier
//   mul_product/mul_zero_out  - multiplier result, valid MUL_LATENCY cycles later
//   out_valid/out_ready       - result stream handshake
//   out_data/out_zero         - FIFO head product and zero flag
//   issued_cnt                - accepted pairs, wraps at 2^32
// Credit covers buffered plus in-flight results, so a result never arrives
// at a full FIFO and out_ready has no combinational path to in_ready.
module fpm_stream_feeder
    import fpm_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_zero_a,
    output logic             mul_zero_b,
    input  logic [WIDTH-1:0] mul_product,
    input  logic             mul_zero_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [31:0]      issued_cnt
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [MUL_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [31:0]            issued_q, issued_d;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          inflight;
    logic [CW:0]            pending;
    logic [WIDTH:0]         head;
    logic                   accept, push, pop;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            inflight = inflight + CW'(vpipe_q[i]);
        end
        pending  = {1'b0, fifo_count} + (CW+1)'(inflight);
        in_ready = !rst && (pending < (CW+1)'(FIFO_DEPTH));
        accept   = in_valid && in_ready;

        mul_a      = accept ? in_a : '0;
        mul_b      = accept ? in_b : '0;
        mul_zero_a = accept && is_fp_zero(in_a);
        mul_zero_b = accept && is_fp_zero(in_b);

        vpipe_d    = '0;
        vpipe_d[0] = accept;
        for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        issued_d  = issued_q + (accept ? 32'd1 : 32'd0);
        push      = vpipe_q[MUL_LATENCY-1];
        out_valid = !rst && (fifo_count != '0);
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q  <= '0;
            issued_q <= '0;
        end else begin
            vpipe_q  <= vpipe_d;
            issued_q <= issued_d;
        end
    end

    fpm_result_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({mul_zero_out, mul_product}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign out_data   = head[WIDTH-1:0];
    assign out_zero   = head[WIDTH];
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_fpm_stream_feeder.sv
module tb_fpm_stream_feeder;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_a, in_b, mul_a, mul_b, mul_product, out_data, issued_cnt;
    logic        mul_zero_a, mul_zero_b, mul_zero_out;

    // standalone FIFO instance for the full push+pop case
    logic        f_push, f_pop;
    logic [32:0] f_din, f_dout;
    logic [2:0]  f_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpm_stream_feeder #(
        .WIDTH       (32),
        .MUL_LATENCY (2),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_zero_a   (mul_zero_a),
        .mul_zero_b   (mul_zero_b),
        .mul_product  (mul_product),
        .mul_zero_out (mul_zero_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_zero     (out_zero),
        .issued_cnt   (issued_cnt)
    );

    fpm_result_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_f5 (
        .clk       (clk),
        .rst       (rst),
        .push      (f_push),
        .push_data (f_din),
        .pop       (f_pop),
        .pop_data  (f_dout),
        .count     (f_cnt)
    );

    // ---------------- FP helpers (via double precision) ----------------
    function automatic logic fz(input logic [31:0] x);
        return ((x >> 23) & 32'hFF) == 32'h0;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (fz(x)) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Expected {isZeroOut, product} for an operand pair.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        if (fz(a) || fz(b)) return {1'b1, a[31] ^ b[31], 31'h0};
        return {1'b0, r2f(f2r(a) * f2r(b))};
    endfunction

    // ---------------- multiplier stand-in: 2 register stages ----------------
    logic [32:0] m1_q, m2_q;
    always @(posedge clk) begin
        if (mul_zero_a || mul_zero_b) m1_q <= {1'b1, mul_a[31] ^ mul_b[31], 31'h0};
        else                          m1_q <= {1'b0, r2f(f2r(mul_a) * f2r(mul_b))};
        m2_q <= m1_q;
    end
    assign mul_product  = m2_q[31:0];
    assign mul_zero_out = m2_q[32];

    // ---------------- reference model state ----------------
    typedef struct {
        logic [32:0] r;
        int unsigned rdy;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    logic [31:0] model_issued = '0;
    logic        last_acc;
    int          pop_cnt, first_pop, last_pop;
    logic [31:0] pool [10] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000,
                               32'hC0000000, 32'hBF000000, 32'h80000000, 32'h00000001,
                               32'h00000000, 32'h3E800000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs at the falling edge, then update the model
    // with what the rising edge does. Returns #1 after the rising edge.
    task automatic tick();
        logic  acc, pop, exp_ir, exp_ov;
        exp_t  e;
        @(negedge clk);
        exp_ir = !rst && (sb.size() < DEPTH);
        chk("in_ready", in_ready, exp_ir);
        acc = in_valid && exp_ir;
        chk("mul_a", mul_a, acc ? in_a : 32'h0);
        chk("mul_b", mul_b, acc ? in_b : 32'h0);
        chk("mul_zero_a", mul_zero_a, acc && fz(in_a));
        chk("mul_zero_b", mul_zero_b, acc && fz(in_b));
        exp_ov = !rst && (sb.size() != 0) && (cyc >= sb[0].rdy);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_data", out_data, sb[0].r[31:0]);
            chk("out_zero", out_zero, sb[0].r[32]);
        end
        if (!rst) chk("issued_cnt", issued_cnt, model_issued);
        pop = exp_ov && out_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            sb.delete();
            model_issued = '0;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                pop_cnt++;
                if (pop_cnt == 1) first_pop = int'(cyc);
                last_pop = int'(cyc);
            end
            if (acc) begin
                e.r   = ref_mul(in_a, in_b);
                e.rdy = cyc + 2;
                sb.push_back(e);
                model_issued++;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int acc_n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; f_push = 1'b0; f_pop = 1'b0; f_din = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_issued", issued_cnt, 32'h0);
        tick();

        // 1: single pair 2.0 * 3.0
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_data, 32'h40C00000);
        chk("t1_zero", out_zero, 1'b0);
        drain();

        // 2: zero and denormal operands
        in_valid = 1'b1; in_a = 32'h80000000; in_b = 32'h40400000;
        #1;
        chk("t2_zero_a", mul_zero_a, 1'b1);
        chk("t2_zero_b", mul_zero_b, 1'b0);
        tick();
        in_a = 32'h00000001;
        #1;
        chk("t2_denorm_a", mul_zero_a, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_out_zero", out_zero, 1'b1);
        drain();

        // 3: backpressure, exactly DEPTH accepted
        out_ready = 1'b0; acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_a = pool[$urandom_range(0, 9)];
            in_b = pool[$urandom_range(0, 9)];
            tick();
            if (last_acc) acc_n++;
        end
        chk("t3_accepted", acc_n, 4);
        chk("t3_ready_low", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        tick();
        chk("t3_resume", last_acc, 1'b1);
        in_valid = 1'b0;
        drain();

        // 4: streaming 100 x (1.5 * 1.5)
        pulse_rst();
        pop_cnt = 0; acc_n = 0;
        in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h3FC00000;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (last_acc) acc_n++;
        end
        in_valid = 1'b0;
        drain();
        chk("t4_accepted", acc_n, 100);
        chk("t4_outputs", pop_cnt, 100);
        chk("t4_consecutive", last_pop - first_pop, 99);
        chk("t4_issued", issued_cnt, 32'd100);

        // 5: full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1; f_din = 33'h1_000000A0 + 33'(i);
            tick();
        end
        chk("t5_full_cnt", f_cnt, 3'd4);
        chk("t5_head0", f_dout, 33'h1_000000A0);
        f_pop = 1'b1; f_din = 33'h0_000000EE;
        tick();
        f_push = 1'b0;
        chk("t5_cnt_same", f_cnt, 3'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", f_dout, (i < 3) ? (33'h1_000000A1 + 33'(i)) : 33'h0_000000EE);
            tick();
        end
        f_pop = 1'b0;
        chk("t5_empty", f_cnt, 3'd0);

        // 6: reset with results buffered and in flight
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = pool[$urandom_range(0, 5)]; in_b = pool[$urandom_range(0, 5)];
            tick();
        end
        in_valid = 1'b0;
        pulse_rst();
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_issued", issued_cnt, 32'h0);
        out_ready = 1'b1;
        repeat (8) tick();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = pool[$urandom_range(0, 9)];
            in_b = pool[$urandom_range(0, 9)];
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
